// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline <-> hazard unit signal bundle
interface hazard_control_unit_if #(
  parameter int CNT_W = 16
);
  // Hazard detection inputs driven by the pipeline
  logic             MemRead_EX_i;
  logic [4:0]       rd_EX_i;
  logic [4:0]       rs1_ID_i;
  logic [4:0]       rs2_ID_i;
  logic             use_rs1_ID_i;
  logic             use_rs2_ID_i;
  logic             branch_taken_EX_i;
  logic             mem_busy_i;

  // Pipeline control returned by the hazard unit
  logic             pc_write_o;
  logic             if_id_write_o;
  logic             id_ex_write_o;
  logic             ex_mem_write_o;
  logic             mem_wb_write_o;
  logic             if_id_flush_o;
  logic             id_ex_flush_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output MemRead_EX_i, rd_EX_i, rs1_ID_i, rs2_ID_i,
    output use_rs1_ID_i, use_rs2_ID_i, branch_taken_EX_i, mem_busy_i,
    input  pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o, mem_wb_write_o,
    input  if_id_flush_o, id_ex_flush_o, state_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  MemRead_EX_i, rd_EX_i, rs1_ID_i, rs2_ID_i,
    input  use_rs1_ID_i, use_rs2_ID_i, branch_taken_EX_i, mem_busy_i,
    output pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o, mem_wb_write_o,
    output if_id_flush_o, id_ex_flush_o, state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use stall, branch flush and memory freeze control
module hazard_control_unit #(
  parameter int LOAD_STALL_CYCLES = 1,  // bubbles per load-use hazard, 1..3
  parameter int CNT_W             = 16
) (
  input logic                  clk,
  input logic                  reset,
  hazard_control_unit_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FREEZE   = 2'b10
  } state_t;

  localparam logic [1:0] LOAD_INIT = 2'(LOAD_STALL_CYCLES - 1);

  state_t           state, state_nxt;
  state_t           ret_state, ret_nxt;
  state_t           eff_state;
  logic [1:0]       dcnt, dcnt_nxt;
  logic             lu;
  logic             pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic             if_id_flush, id_ex_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Load-use detection: a load in EX whose destination is really read by ID
  always_comb begin
    lu = hz.MemRead_EX_i && (hz.rd_EX_i != 5'd0) &&
         ((hz.use_rs1_ID_i && (hz.rs1_ID_i == hz.rd_EX_i)) ||
          (hz.use_rs2_ID_i && (hz.rs2_ID_i == hz.rd_EX_i)));
  end

  // Priority-ordered control decode; FREEZE behaves as the state it interrupted
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_write = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    state_nxt    = state;
    ret_nxt      = ret_state;
    dcnt_nxt     = dcnt;
    eff_state    = (state == FREEZE) ? ret_state : state;

    if (reset) begin
      // everything held off while reset is applied
      state_nxt = RUN;
    end else if (hz.mem_busy_i) begin
      // whole pipeline frozen; remember what to resume, keep remaining count
      state_nxt = FREEZE;
      ret_nxt   = eff_state;
    end else if (hz.branch_taken_EX_i) begin
      // wrong-path instructions in IF/ID and ID/EX are squashed, any stall dropped
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      state_nxt    = RUN;
      ret_nxt      = RUN;
      dcnt_nxt     = 2'd0;
    end else if (eff_state == LU_STALL) begin
      // continuing bubble insertion; older instructions keep draining
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      id_ex_flush  = 1'b1;
      dcnt_nxt     = dcnt - 2'd1;
      state_nxt    = (dcnt <= 2'd1) ? RUN : LU_STALL;
      ret_nxt      = RUN;
    end else if (lu) begin
      // first bubble of a load-use stall
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      id_ex_flush  = 1'b1;
      ret_nxt      = RUN;
      if (LOAD_STALL_CYCLES == 1) begin
        state_nxt = RUN;
      end else begin
        state_nxt = LU_STALL;
        dcnt_nxt  = LOAD_INIT;
      end
    end else begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      state_nxt    = RUN;
      ret_nxt      = RUN;
    end
  end

  // FSM state, freeze return state and stall down-counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      ret_state <= RUN;
      dcnt      <= 2'd0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      dcnt      <= dcnt_nxt;
    end
  end

  // Saturating performance counters for stalled and flushed cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (if_id_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign hz.pc_write_o     = pc_write;
  assign hz.if_id_write_o  = if_id_write;
  assign hz.id_ex_write_o  = id_ex_write;
  assign hz.ex_mem_write_o = ex_mem_write;
  assign hz.mem_wb_write_o = mem_wb_write;
  assign hz.if_id_flush_o  = if_id_flush;
  assign hz.id_ex_flush_o  = id_ex_flush;
  assign hz.state_o        = state;
  assign hz.stall_cnt_o    = stall_cnt;
  assign hz.flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_fail;
  int   n_total;

  hazard_control_unit_if #(.CNT_W(16)) b1 ();
  hazard_control_unit_if #(.CNT_W(16)) b2 ();
  hazard_control_unit_if #(.CNT_W(16)) b3 ();
  hazard_control_unit_if #(.CNT_W(4))  b4 ();

  hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .hz(b1));
  hazard_control_unit #(.LOAD_STALL_CYCLES(2), .CNT_W(16)) u2 (.clk(clk), .reset(reset), .hz(b2));
  hazard_control_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u3 (.clk(clk), .reset(reset), .hz(b3));
  hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(4))  u4 (.clk(clk), .reset(reset), .hz(b4));

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net against a hung run
  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u_rs1, input logic u_rs2,
                       input logic br, input logic mb);
    case (which)
      1: begin
        b1.MemRead_EX_i = mr; b1.rd_EX_i = rd; b1.rs1_ID_i = rs1; b1.rs2_ID_i = rs2;
        b1.use_rs1_ID_i = u_rs1; b1.use_rs2_ID_i = u_rs2;
        b1.branch_taken_EX_i = br; b1.mem_busy_i = mb;
      end
      2: begin
        b2.MemRead_EX_i = mr; b2.rd_EX_i = rd; b2.rs1_ID_i = rs1; b2.rs2_ID_i = rs2;
        b2.use_rs1_ID_i = u_rs1; b2.use_rs2_ID_i = u_rs2;
        b2.branch_taken_EX_i = br; b2.mem_busy_i = mb;
      end
      3: begin
        b3.MemRead_EX_i = mr; b3.rd_EX_i = rd; b3.rs1_ID_i = rs1; b3.rs2_ID_i = rs2;
        b3.use_rs1_ID_i = u_rs1; b3.use_rs2_ID_i = u_rs2;
        b3.branch_taken_EX_i = br; b3.mem_busy_i = mb;
      end
      default: begin
        b4.MemRead_EX_i = mr; b4.rd_EX_i = rd; b4.rs1_ID_i = rs1; b4.rs2_ID_i = rs2;
        b4.use_rs1_ID_i = u_rs1; b4.use_rs2_ID_i = u_rs2;
        b4.branch_taken_EX_i = br; b4.mem_busy_i = mb;
      end
    endcase
  endtask

  task automatic idle(input int which);
    drive(which, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_use(input int which);
    drive(which, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_pass  = 0;
    n_fail  = 0;
    n_total = 0;
    reset   = 1'b1;
    for (int k = 1; k <= 4; k++) idle(k);

    // Reset state
    #2;
    chk("rst_pc_write", b1.pc_write_o, 0);
    chk("rst_mem_wb_write", b1.mem_wb_write_o, 0);
    chk("rst_state", b1.state_o, 0);
    chk("rst_stall_cnt", b1.stall_cnt_o, 0);
    chk("rst_flush_cnt", b1.flush_cnt_o, 0);
    chk("rst_u4_stall_cnt", b4.stall_cnt_o, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("run_pc_write", b1.pc_write_o, 1);
    chk("run_id_ex_flush", b1.id_ex_flush_o, 0);

    // Load-use via rs1 with one bubble
    tick();
    load_use(1);
    #1;
    chk("lu1_pc_write", b1.pc_write_o, 0);
    chk("lu1_if_id_write", b1.if_id_write_o, 0);
    chk("lu1_id_ex_flush", b1.id_ex_flush_o, 1);
    chk("lu1_id_ex_write", b1.id_ex_write_o, 1);
    chk("lu1_if_id_flush", b1.if_id_flush_o, 0);
    chk("lu1_stall_before", b1.stall_cnt_o, 0);
    tick();
    chk("lu1_stall_after", b1.stall_cnt_o, 1);
    chk("lu1_state_run", b1.state_o, 0);
    // Same pattern with rd=0 is not a hazard
    drive(1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rd0_pc_write", b1.pc_write_o, 1);
    chk("rd0_id_ex_flush", b1.id_ex_flush_o, 0);
    tick();
    chk("rd0_stall_cnt", b1.stall_cnt_o, 1);
    // Hazard through rs2 only
    drive(1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rs2_pc_write", b1.pc_write_o, 0);
    tick();
    chk("rs2_stall_cnt", b1.stall_cnt_o, 2);
    // Matching rs2 that is not actually read
    drive(1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("nouse_pc_write", b1.pc_write_o, 1);
    // Branch together with load-use: branch wins
    drive(1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("brlu_pc_write", b1.pc_write_o, 1);
    chk("brlu_if_id_flush", b1.if_id_flush_o, 1);
    chk("brlu_id_ex_flush", b1.id_ex_flush_o, 1);
    tick();
    chk("brlu_flush_cnt", b1.flush_cnt_o, 1);
    chk("brlu_stall_cnt", b1.stall_cnt_o, 2);
    idle(1);

    // Three-cycle load-use stall
    load_use(3);
    #1;
    chk("ls3_c1_pc_write", b3.pc_write_o, 0);
    chk("ls3_c1_state", b3.state_o, 0);
    tick();
    idle(3);
    #1;
    chk("ls3_c2_pc_write", b3.pc_write_o, 0);
    chk("ls3_c2_state", b3.state_o, 1);
    tick();
    chk("ls3_c3_pc_write", b3.pc_write_o, 0);
    chk("ls3_c3_state", b3.state_o, 1);
    tick();
    chk("ls3_end_pc_write", b3.pc_write_o, 1);
    chk("ls3_end_state", b3.state_o, 0);
    chk("ls3_stall_cnt", b3.stall_cnt_o, 3);

    // Branch during second stall cycle aborts the stall
    load_use(3);
    tick();
    drive(3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("ab_if_id_flush", b3.if_id_flush_o, 1);
    chk("ab_id_ex_flush", b3.id_ex_flush_o, 1);
    chk("ab_pc_write", b3.pc_write_o, 1);
    chk("ab_if_id_write", b3.if_id_write_o, 1);
    chk("ab_ex_mem_write", b3.ex_mem_write_o, 1);
    tick();
    idle(3);
    #1;
    chk("ab_state", b3.state_o, 0);
    chk("ab_flush_cnt", b3.flush_cnt_o, 1);
    chk("ab_stall_cnt", b3.stall_cnt_o, 4);
    chk("ab_resume_pc_write", b3.pc_write_o, 1);

    // Freeze in the middle of a two-cycle stall
    load_use(2);
    tick();
    chk("fz_lu_state", b2.state_o, 1);
    chk("fz_lu_stall", b2.stall_cnt_o, 1);
    drive(2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("fz_b1_pc_write", b2.pc_write_o, 0);
    chk("fz_b1_id_ex_write", b2.id_ex_write_o, 0);
    chk("fz_b1_mem_wb_write", b2.mem_wb_write_o, 0);
    chk("fz_b1_id_ex_flush", b2.id_ex_flush_o, 0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("fz_bn_state", b2.state_o, 2);
      chk("fz_bn_ex_mem_write", b2.ex_mem_write_o, 0);
    end
    tick();
    idle(2);
    #1;
    chk("fz_res_state", b2.state_o, 2);
    chk("fz_res_pc_write", b2.pc_write_o, 0);
    chk("fz_res_id_ex_write", b2.id_ex_write_o, 1);
    chk("fz_res_id_ex_flush", b2.id_ex_flush_o, 1);
    tick();
    chk("fz_end_state", b2.state_o, 0);
    chk("fz_end_pc_write", b2.pc_write_o, 1);
    chk("fz_end_stall_cnt", b2.stall_cnt_o, 6);

    // Saturation of a 4-bit stall counter
    load_use(4);
    for (int k = 0; k < 14; k++) tick();
    chk("sat_14", b4.stall_cnt_o, 14);
    tick();
    chk("sat_15", b4.stall_cnt_o, 15);
    for (int k = 0; k < 5; k++) tick();
    chk("sat_hold", b4.stall_cnt_o, 15);
    idle(4);

    // Reset while in LU_STALL with seven stall cycles counted
    drive(3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("pre_fz_pc_write", b3.pc_write_o, 0);
    tick();
    chk("pre_fz_state", b3.state_o, 2);
    load_use(3);
    #1;
    chk("pre_lu_id_ex_flush", b3.id_ex_flush_o, 1);
    tick();
    idle(3);
    tick();
    chk("pre_rst_state", b3.state_o, 1);
    chk("pre_rst_stall_cnt", b3.stall_cnt_o, 7);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_state", b3.state_o, 0);
    chk("mid_rst_stall_cnt", b3.stall_cnt_o, 0);
    chk("mid_rst_pc_write", b3.pc_write_o, 0);
    chk("mid_rst_id_ex_write", b3.id_ex_write_o, 0);
    chk("mid_rst_mem_wb_write", b3.mem_wb_write_o, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_pc_write", b3.pc_write_o, 1);
    chk("post_rst_if_id_write", b3.if_id_write_o, 1);
    chk("post_rst_ex_mem_write", b3.ex_mem_write_o, 1);
    chk("post_rst_mem_wb_write", b3.mem_wb_write_o, 1);
    tick();
    chk("post_rst_state", b3.state_o, 0);
    chk("post_rst_stall_cnt", b3.stall_cnt_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
